// File: rtl/dmem_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : dmem_port_arbiter
// Summary  : Shares the single-port, byte-addressed data memory between the
//            CPU MEM stage and a debug/loader port. Accesses are serialised
//            through a req/ack handshake, memory read latency is hidden, and
//            cpu_stall freezes the pipeline while a CPU access is outstanding.
// Options  : DMEM_ARB_STARVE_EN - when defined, the debug port is guaranteed
//            a grant after STARVE_MAX consecutive CPU grants it waited behind.
//            When undefined, the CPU has strict priority.
// Revision : 1.0 - initial release
//==============================================================================
module dmem_port_arbiter #(
    parameter int ADDR_W     = 7,   // byte-address width
    parameter int MEM_LAT    = 1,   // memory read latency, 1..7 cycles
    parameter int STARVE_MAX = 4    // CPU grants tolerated while dbg waits
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low

    // CPU MEM-stage port
    input  logic              cpu_req,
    input  logic [3:0]        cpu_re,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,

    // Debug / loader port
    input  logic              dbg_req,
    input  logic [3:0]        dbg_re,
    input  logic [3:0]        dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_ack,

    // Memory side
    output logic              mem_en,
    output logic [3:0]        mem_re,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,

    // Status
    output logic              owner,      // 0 = CPU, 1 = dbg (current or last)
    busy
);

    // Last WAIT-cycle count value: WAIT lasts exactly MEM_LAT cycles.
    localparam logic [2:0] c_LAT_LAST = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    // Latched copy of the granted request
    logic               r_owner;
    logic [ADDR_W-1:0]  r_addr;
    logic [3:0]         r_re;
    logic [3:0]         r_we;
    logic [31:0]        r_wdata;

    logic [2:0]         r_lat_cnt;
    logic [31:0]        r_cpu_rdata;
    logic [31:0]        r_dbg_rdata;

    logic               w_grant;      // a request is accepted this cycle
    logic               w_dbg_wins;   // arbitration result if granting
    logic               w_capture;    // mem_rdata is valid this cycle
    logic               w_is_write;   // any write lane set (write wins over read)
    logic               w_is_read;    // pure read
    logic               w_starved;    // debug port has waited long enough
    logic               w_done;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [2:0] c_STARVE_MAX = 3'(STARVE_MAX);

    logic [2:0]         r_starve_cnt;

    assign w_starved = (r_starve_cnt >= c_STARVE_MAX);

    // Count CPU grants that bypassed a waiting debug request; any debug
    // grant or an idle debug port restarts the count. Saturates at 7.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= 3'd0;
        end else if (!dbg_req) begin
            r_starve_cnt <= 3'd0;
        end else if (w_grant && w_dbg_wins) begin
            r_starve_cnt <= 3'd0;
        end else if (w_grant && (r_starve_cnt != 3'd7)) begin
            r_starve_cnt <= r_starve_cnt + 3'd1;
        end
    end
`else
    logic               w_unused_starve_max;

    // Strict CPU priority: the debug port never preempts a CPU request.
    assign w_starved           = 1'b0;
    assign w_unused_starve_max = (STARVE_MAX != 0);
`endif

    // Debug wins when it is the only requester, or when it has been starved.
    assign w_dbg_wins = dbg_req & (~cpu_req | w_starved);

    assign w_is_write = |r_we;
    assign w_is_read  = ~w_is_write & (|r_re);
    assign w_done     = (r_state == ST_DONE);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and memory-side outputs driven from the latched request
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_capture    = 1'b0;
        mem_en       = 1'b0;
        mem_re       = 4'd0;
        mem_we       = 4'd0;
        mem_addr     = '0;
        mem_wdata    = 32'd0;

        case (r_state)
            ST_IDLE: begin
                if (cpu_req || dbg_req) begin
                    w_grant      = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // A null access leaves the strobe low but still completes.
                mem_en    = w_is_write | (|r_re);
                mem_we    = r_we;
                mem_re    = w_is_write ? 4'd0 : r_re;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                w_next_state = w_is_read ? ST_WAIT : ST_DONE;
            end

            ST_WAIT: begin
                if (r_lat_cnt == c_LAT_LAST) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_DONE;
                end
            end

            ST_DONE: begin
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Latch the granted request, run the latency counter, capture read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner     <= 1'b0;
            r_addr      <= '0;
            r_re        <= 4'd0;
            r_we        <= 4'd0;
            r_wdata     <= 32'd0;
            r_lat_cnt   <= 3'd0;
            r_cpu_rdata <= 32'd0;
            r_dbg_rdata <= 32'd0;
        end else begin
            if (w_grant) begin
                r_owner <= w_dbg_wins;
                if (w_dbg_wins) begin
                    r_addr  <= dbg_addr;
                    r_re    <= dbg_re;
                    r_we    <= dbg_we;
                    r_wdata <= dbg_wdata;
                end else begin
                    r_addr  <= cpu_addr;
                    r_re    <= cpu_re;
                    r_we    <= cpu_we;
                    r_wdata <= cpu_wdata;
                end
            end

            if (r_state == ST_ISSUE) begin
                r_lat_cnt <= 3'd0;
            end else if (r_state == ST_WAIT) begin
                r_lat_cnt <= r_lat_cnt + 3'd1;
            end

            // Each requester's read register changes only on its own read.
            if (w_capture) begin
                if (r_owner) begin
                    r_dbg_rdata <= mem_rdata;
                end else begin
                    r_cpu_rdata <= mem_rdata;
                end
            end
        end
    end

    // Completion pulses and status
    assign cpu_ack   = w_done & ~r_owner;
    assign dbg_ack   = w_done &  r_owner;
    assign cpu_rdata = r_cpu_rdata;
    assign dbg_rdata = r_dbg_rdata;
    assign owner     = r_owner;
    assign busy      = (r_state != ST_IDLE);

    // Stall is held low while reset is asserted so every output reads 0.
    assign cpu_stall = reset & cpu_req & ~cpu_ack;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_dmem_port_arbiter
// Summary  : Self-checking bench for dmem_port_arbiter. A transaction-level
//            model predicts grant order, ack cycles, read data and owner from
//            the arbitration rules; a byte-array memory with MEM_LAT latency
//            sits on the memory port.
// Revision : 1.0 - initial release
//==============================================================================
module tb_dmem_port_arbiter;

    localparam int ADDR_W     = 7;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_ON  = 1'b1;
`else
    localparam bit STARVE_ON  = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        cpu_req, dbg_req;
    logic [3:0]  cpu_re, cpu_we, dbg_re, dbg_we;
    logic [6:0]  cpu_addr, dbg_addr;
    logic [31:0] cpu_wdata, dbg_wdata;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        cpu_ack, dbg_ack, cpu_stall;
    logic        mem_en;
    logic [3:0]  mem_re, mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        owner, busy;

    dmem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_re    (dbg_re),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .dbg_ack   (dbg_ack),
        .mem_en    (mem_en),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  re;
        logic [3:0]  we;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } op_t;

    typedef struct {
        bit          who;     // 0 = CPU, 1 = dbg
        int          grant;   // cycle the request is accepted
        int          ack;     // cycle of the ack pulse
        op_t         op;
        logic [31:0] rdata;   // requester's rdata expected at ack
    } exp_t;

    op_t         cq[$];
    op_t         dq[$];
    exp_t        ex[$];
    logic [7:0]  mem     [0:127];
    logic [7:0]  ref_mem [0:127];
    logic [31:0] rd_pipe [0:MEM_LAT-1];
    logic        mem_load;
    logic [31:0] m_cpu_rdata, m_dbg_rdata;
    bit          m_owner;
    int          n_checks, n_fail;

    // Memory on the arbiter's memory port: big-endian lanes, MEM_LAT read delay.
    // Cycles without a read push random data so a mistimed capture shows up.
    always @(posedge clk) begin
        logic [31:0] w;
        logic [6:0]  a;
        w = $urandom;
        if (mem_load) begin
            for (int i = 0; i < 128; i++) mem[i] <= ref_mem[i];
        end else if (mem_en) begin
            if (mem_re != 4'd0) begin
                w = 32'd0;
                for (int j = 0; j < 4; j++) begin
                    a = mem_addr + 7'(3 - j);
                    if (mem_re[j]) w[8*j +: 8] = mem[a];
                end
            end
            for (int i = 0; i < 4; i++) begin
                a = mem_addr + 7'(i);
                if (mem_we[i]) mem[a] <= mem_wdata[31-8*i -: 8];
            end
        end
        rd_pipe[0] <= w;
        for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input op_t op);
        logic [31:0] w;
        logic [6:0]  a;
        w = 32'd0;
        for (int j = 0; j < 4; j++) begin
            a = op.addr + 7'(3 - j);
            if (op.re[j]) w[8*j +: 8] = ref_mem[a];
        end
        return w;
    endfunction

    // Transaction-level prediction: both queues present at cycle 0, each
    // requester presents its next op the cycle after its ack.
    task automatic build_model();
        int   t, ci, di, starve, lat;
        bit   cp, dp, dw, rd;
        op_t  op;
        exp_t e;
        logic [6:0] a;
        t = 0; ci = 0; di = 0; starve = 0;
        ex.delete();
        while (ci < cq.size() || di < dq.size()) begin
            cp = (ci < cq.size());
            dp = (di < dq.size());
            dw = dp && (!cp || (STARVE_ON && starve >= STARVE_MAX));
            if (!dp || dw) starve = 0;
            else if (starve < 7) starve++;
            if (dw) begin op = dq[di]; di++; end
            else    begin op = cq[ci]; ci++; end
            rd  = (op.we == 4'd0) && (op.re != 4'd0);
            lat = rd ? MEM_LAT + 2 : 2;
            if (op.we != 4'd0) begin
                for (int i = 0; i < 4; i++) begin
                    a = op.addr + 7'(i);
                    if (op.we[i]) ref_mem[a] = op.wdata[31-8*i -: 8];
                end
            end else if (rd) begin
                if (dw) m_dbg_rdata = ref_read(op);
                else    m_cpu_rdata = ref_read(op);
            end
            e.who   = dw;
            e.grant = t;
            e.ack   = t + lat;
            e.op    = op;
            e.rdata = dw ? m_dbg_rdata : m_cpu_rdata;
            ex.push_back(e);
            t = e.ack + 1;
        end
    endtask

    task automatic drive(input int ci, input int di);
        op_t o;
        if (ci < cq.size()) begin
            o = cq[ci];
            cpu_req = 1'b1;
        end else begin
            o = op_t'({$urandom, $urandom});
            cpu_req = 1'b0;
        end
        {cpu_re, cpu_we, cpu_addr, cpu_wdata} = o;
        if (di < dq.size()) begin
            o = dq[di];
            dbg_req = 1'b1;
        end else begin
            o = op_t'({$urandom, $urandom});
            dbg_req = 1'b0;
        end
        {dbg_re, dbg_we, dbg_addr, dbg_wdata} = o;
    endtask

    task automatic run_scenario(input string name);
        int   ci, di, last, k_issue, k_ack;
        bit   e_cack, e_dack, e_busy, e_owner, e_en, obs_c, obs_d;
        op_t  op;
        build_model();
        last = ex[ex.size()-1].ack;
        ci = 0; di = 0;
        @(posedge clk); #1;
        drive(ci, di);
        for (int c = 0; c <= last + 1; c++) begin
            #1;
            e_cack = 0; e_dack = 0; e_busy = 0; e_owner = m_owner;
            k_issue = -1; k_ack = -1;
            foreach (ex[k]) begin
                if (ex[k].ack == c) begin
                    k_ack = k;
                    if (ex[k].who) e_dack = 1; else e_cack = 1;
                end
                if (ex[k].grant + 1 <= c && c <= ex[k].ack) e_busy = 1;
                if (ex[k].grant + 1 == c) k_issue = k;
                if (ex[k].grant < c) e_owner = ex[k].who;
            end
            check_value({name, " cpu_ack"}, cpu_ack, e_cack);
            check_value({name, " dbg_ack"}, dbg_ack, e_dack);
            check_value({name, " busy"}, busy, e_busy);
            check_value({name, " owner"}, owner, e_owner);
            check_value({name, " cpu_stall"}, cpu_stall, cpu_req & ~e_cack);
            if (k_ack >= 0) begin
                if (ex[k_ack].who) check_value({name, " dbg_rdata"}, dbg_rdata, ex[k_ack].rdata);
                else               check_value({name, " cpu_rdata"}, cpu_rdata, ex[k_ack].rdata);
            end
            if (k_issue >= 0) begin
                op   = ex[k_issue].op;
                e_en = (op.we != 4'd0) || (op.re != 4'd0);
                check_value({name, " mem_en"}, mem_en, e_en);
                if (e_en) begin
                    check_value({name, " mem_we"}, mem_we, op.we);
                    check_value({name, " mem_re"}, mem_re, (op.we != 4'd0) ? 4'd0 : op.re);
                    check_value({name, " mem_addr"}, mem_addr, op.addr);
                    if (op.we != 4'd0) check_value({name, " mem_wdata"}, mem_wdata, op.wdata);
                end
            end else begin
                check_value({name, " mem_en idle"}, mem_en, 1'b0);
            end
            obs_c = cpu_ack;
            obs_d = dbg_ack;
            @(posedge clk); #1;
            if (obs_c) ci++;
            if (obs_d) di++;
            drive(ci, di);
        end
        check_value({name, " cpu txn count"}, ci, cq.size());
        check_value({name, " dbg txn count"}, di, dq.size());
        m_owner = ex[ex.size()-1].who;
    endtask

    task automatic check_all_zero(input string name);
        check_value({name, " mem_en"}, mem_en, 0);
        check_value({name, " mem_re"}, mem_re, 0);
        check_value({name, " mem_we"}, mem_we, 0);
        check_value({name, " mem_addr"}, mem_addr, 0);
        check_value({name, " mem_wdata"}, mem_wdata, 0);
        check_value({name, " cpu_ack"}, cpu_ack, 0);
        check_value({name, " dbg_ack"}, dbg_ack, 0);
        check_value({name, " cpu_stall"}, cpu_stall, 0);
        check_value({name, " busy"}, busy, 0);
        check_value({name, " owner"}, owner, 0);
        check_value({name, " cpu_rdata"}, cpu_rdata, 0);
        check_value({name, " dbg_rdata"}, dbg_rdata, 0);
    endtask

    function automatic op_t mk_op(input logic [3:0] re, input logic [3:0] we,
                                  input logic [6:0] addr, input logic [31:0] wdata);
        op_t o;
        o.re = re; o.we = we; o.addr = addr; o.wdata = wdata;
        return o;
    endfunction

    function automatic op_t rand_op();
        int kind;
        kind = $urandom_range(0, 6);
        case (kind)
            0, 1, 2: return mk_op(4'($urandom_range(1, 15)), 4'd0, 7'($urandom), $urandom);
            3, 4:    return mk_op(4'd0, 4'($urandom_range(1, 15)), 7'($urandom), $urandom);
            5:       return mk_op(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 7'($urandom), $urandom);
            default: return mk_op(4'd0, 4'd0, 7'($urandom), $urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nc, nd;
        n_checks = 0; n_fail = 0;
        m_cpu_rdata = 32'd0; m_dbg_rdata = 32'd0; m_owner = 1'b0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'($urandom);
        cq.delete(); dq.delete();
        reset = 1'b0;
        mem_load = 1'b1;
        drive(0, 0);
        repeat (3) @(posedge clk);
        #1;
        mem_load = 1'b0;
        check_all_zero("reset state");
        reset = 1'b1;

        // Write then read back at 0x10
        cq.delete(); dq.delete();
        cq.push_back(mk_op(4'd0, 4'hF, 7'h10, 32'hDEADBEEF));
        cq.push_back(mk_op(4'hF, 4'd0, 7'h10, 32'h0));
        run_scenario("cpu wr/rd");

        // Null access keeps rdata
        cq.delete(); dq.delete();
        cq.push_back(mk_op(4'd0, 4'hF, 7'h20, 32'h12345678));
        cq.push_back(mk_op(4'hF, 4'd0, 7'h20, 32'h0));
        cq.push_back(mk_op(4'd0, 4'd0, 7'h20, 32'hFFFFFFFF));
        run_scenario("null");

        // Reset during WAIT of a CPU read
        @(posedge clk); #1;
        cq.delete(); dq.delete();
        cq.push_back(mk_op(4'hF, 4'd0, 7'h10, 32'h0));
        drive(0, 0);
        @(posedge clk); #1;     // ISSUE
        @(posedge clk); #1;     // WAIT
        reset = 1'b0;
        repeat (2) begin
            #1;
            check_value("rst wait cpu_ack", cpu_ack, 0);
            check_value("rst wait cpu_rdata", cpu_rdata, 0);
            check_value("rst wait mem_en", mem_en, 0);
            @(posedge clk); #1;
        end
        cq.delete();
        drive(0, 0);
        reset = 1'b1;
        m_cpu_rdata = 32'd0; m_dbg_rdata = 32'd0; m_owner = 1'b0;
        cq.push_back(mk_op(4'hF, 4'd0, 7'h10, 32'h0));
        run_scenario("read after rst");

        // Simultaneous writes
        cq.delete(); dq.delete();
        cq.push_back(mk_op(4'd0, 4'hF, 7'h30, $urandom));
        dq.push_back(mk_op(4'd0, 4'hF, 7'h40, $urandom));
        run_scenario("collide");

        // Back-to-back CPU traffic against a waiting debug request
        cq.delete(); dq.delete();
        for (int i = 0; i < 6; i++) cq.push_back(mk_op(4'd0, 4'hF, 7'(8 * i), $urandom));
        dq.push_back(mk_op(4'd0, 4'hF, 7'h7E, $urandom));
        dq.push_back(mk_op(4'hF, 4'd0, 7'h7E, 32'h0));
        run_scenario("starve");

        // Reset during traffic (CPU write in ISSUE, dbg read pending)
        @(posedge clk); #1;
        cq.delete(); dq.delete();
        cq.push_back(mk_op(4'd0, 4'hF, 7'h50, 32'hCAFEF00D));
        dq.push_back(mk_op(4'hF, 4'd0, 7'h50, 32'h0));
        drive(0, 0);
        @(posedge clk); #1;     // ISSUE of the CPU write
        reset = 1'b0;
        repeat (3) begin
            #1;
            check_all_zero("rst traffic");
            @(posedge clk); #1;
        end
        cq.delete(); dq.delete();
        drive(0, 0);
        reset = 1'b1;
        m_cpu_rdata = 32'd0; m_dbg_rdata = 32'd0; m_owner = 1'b0;
        dq.push_back(mk_op(4'hF, 4'd0, 7'h50, 32'h0));
        cq.push_back(mk_op(4'd0, 4'h3, 7'h7F, $urandom));
        run_scenario("after rst");

        // Randomized mixes
        for (int s = 0; s < 30; s++) begin
            cq.delete(); dq.delete();
            nc = $urandom_range(0, 3);
            nd = $urandom_range(0, 3);
            if (nc == 0 && nd == 0) nc = 1;
            for (int i = 0; i < nc; i++) cq.push_back(rand_op());
            for (int i = 0; i < nd; i++) dq.push_back(rand_op());
            run_scenario("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
